// File: rtl/ram0_port_arbiter_if.sv
// Bundle of the two requester ports and the RAM0 read/write handshake pins
// seen by ram0_port_arbiter (slave view) and by its requesters (master view).
interface ram0_port_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_sel;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_sel;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic [31:0] ram0_raddr;
  logic        ram0_ren;
  logic [31:0] ram0_rdata;
  logic        ram0_rvalid;
  logic [31:0] ram0_waddr;
  logic [31:0] ram0_wdata;
  logic        ram0_wen;
  logic [3:0]  ram0_sel;
  logic        ram0_wready;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_sel,
    output m0_ack, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_sel,
    output m1_ack, m1_rdata, m1_err,
    output ram0_raddr, ram0_ren, ram0_waddr, ram0_wdata, ram0_wen, ram0_sel,
    input  ram0_rdata, ram0_rvalid, ram0_wready
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_sel,
    input  m0_ack, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_sel,
    input  m1_ack, m1_rdata, m1_err,
    input  ram0_raddr, ram0_ren, ram0_waddr, ram0_wdata, ram0_wen, ram0_sel,
    output ram0_rdata, ram0_rvalid, ram0_wready
  );
endinterface

// File: rtl/ram0_port_arbiter.sv
// Two-requester arbiter for the single RAM0 port (m0 = tinycpu, m1 = loader).
// Optional handshake abort enabled by defining RAM0_ARB_TIMEOUT_EN.
module ram0_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter bit          FIXED_PRIO     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  ram0_port_arbiter_if.slave   bus,
  output logic                 busy,
  output logic                 owner
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic        grant;
  logic        pick_we;
  logic [31:0] pick_addr;
  logic [31:0] pick_wdata;
  logic [3:0]  pick_sel;

`ifdef RAM0_ARB_TIMEOUT_EN
  localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] stall_cnt;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    grant = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      grant = FIXED_PRIO ? 1'b0 : ~owner;
    end
    pick_we    = grant ? bus.m1_we    : bus.m0_we;
    pick_addr  = grant ? bus.m1_addr  : bus.m0_addr;
    pick_wdata = grant ? bus.m1_wdata : bus.m0_wdata;
    pick_sel   = grant ? bus.m1_sel   : bus.m0_sel;
  end

  // The RAM0 address/data outputs double as the transaction latches; they
  // are cleared whenever the matching ren/wen drops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is
    // sampled on the edge, there is no asynchronous path.
    if (!rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      owner           <= 1'b1;
      bus.m0_ack      <= 1'b0;
      bus.m0_err      <= 1'b0;
      bus.m0_rdata    <= '0;
      bus.m1_ack      <= 1'b0;
      bus.m1_err      <= 1'b0;
      bus.m1_rdata    <= '0;
      bus.ram0_raddr  <= '0;
      bus.ram0_ren    <= 1'b0;
      bus.ram0_waddr  <= '0;
      bus.ram0_wdata  <= '0;
      bus.ram0_wen    <= 1'b0;
      bus.ram0_sel    <= '0;
`ifdef RAM0_ARB_TIMEOUT_EN
      stall_cnt       <= '0;
`endif
    end else begin
      bus.m0_ack <= 1'b0;
      bus.m1_ack <= 1'b0;
      bus.m0_err <= 1'b0;
      bus.m1_err <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            owner <= grant;
            busy  <= 1'b1;
`ifdef RAM0_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (pick_we) begin
              bus.ram0_wen   <= 1'b1;
              bus.ram0_waddr <= pick_addr;
              bus.ram0_wdata <= pick_wdata;
              bus.ram0_sel   <= pick_sel;
              state          <= WR;
            end else begin
              bus.ram0_ren   <= 1'b1;
              bus.ram0_raddr <= pick_addr;
              state          <= RD;
            end
          end
        end

        RD: begin
          if (bus.ram0_rvalid) begin
            bus.ram0_ren   <= 1'b0;
            bus.ram0_raddr <= '0;
            state          <= DONE;
            if (owner) begin
              bus.m1_ack   <= 1'b1;
              bus.m1_rdata <= bus.ram0_rdata;
            end else begin
              bus.m0_ack   <= 1'b1;
              bus.m0_rdata <= bus.ram0_rdata;
            end
          end
`ifdef RAM0_ARB_TIMEOUT_EN
          else if (stall_cnt == CNT_LAST) begin
            bus.ram0_ren   <= 1'b0;
            bus.ram0_raddr <= '0;
            state          <= DONE;
            if (owner) begin
              bus.m1_ack   <= 1'b1;
              bus.m1_err   <= 1'b1;
              bus.m1_rdata <= '0;
            end else begin
              bus.m0_ack   <= 1'b1;
              bus.m0_err   <= 1'b1;
              bus.m0_rdata <= '0;
            end
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end

        WR: begin
          if (bus.ram0_wready) begin
            bus.ram0_wen   <= 1'b0;
            bus.ram0_waddr <= '0;
            bus.ram0_wdata <= '0;
            bus.ram0_sel   <= '0;
            state          <= DONE;
            if (owner) bus.m1_ack <= 1'b1;
            else       bus.m0_ack <= 1'b1;
          end
`ifdef RAM0_ARB_TIMEOUT_EN
          else if (stall_cnt == CNT_LAST) begin
            bus.ram0_wen   <= 1'b0;
            bus.ram0_waddr <= '0;
            bus.ram0_wdata <= '0;
            bus.ram0_sel   <= '0;
            state          <= DONE;
            if (owner) begin
              bus.m1_ack <= 1'b1;
              bus.m1_err <= 1'b1;
            end else begin
              bus.m0_ack <= 1'b1;
              bus.m0_err <= 1'b1;
            end
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram0_port_arbiter.sv
// Directed bench for ram0_port_arbiter: reset, read, stalled write,
// round-robin and fixed-priority arbitration, mid-transaction reset, timeout.
module tb_ram0_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, owner, busy_fp, owner_fp;
  int   tests  = 0;
  int   failed = 0;

  ram0_port_arbiter_if bus ();
  ram0_port_arbiter_if bus_fp ();

  ram0_port_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .owner(owner)
  );

  ram0_port_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_fp), .busy(busy_fp), .owner(owner_fp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_sel = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_sel = '0;
    bus.ram0_rdata = '0; bus.ram0_rvalid = 0; bus.ram0_wready = 0;
    bus_fp.m0_req = 0; bus_fp.m0_we = 0; bus_fp.m0_addr = '0; bus_fp.m0_wdata = '0; bus_fp.m0_sel = '0;
    bus_fp.m1_req = 0; bus_fp.m1_we = 0; bus_fp.m1_addr = '0; bus_fp.m1_wdata = '0; bus_fp.m1_sel = '0;
    bus_fp.ram0_rdata = '0; bus_fp.ram0_rvalid = 0; bus_fp.ram0_wready = 0;
  endtask

  task automatic test_reset();
    logic [170:0] outs;
    rst = 0;
    tick();
    tick();
    outs = {bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack, bus.m1_err, bus.m1_rdata,
            bus.ram0_raddr, bus.ram0_ren, bus.ram0_waddr, bus.ram0_wdata, bus.ram0_wen,
            bus.ram0_sel, busy};
    tests++;
    if (outs !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    tests++;
    if (owner !== 1'b1) begin
      failed++;
      $display("FAIL reset_owner: got %b, want 1", owner);
    end
    rst = 1;
  endtask

  task automatic test_read_m0();
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h10;
    bus.ram0_rvalid = 1; bus.ram0_rdata = 32'hCAFE_F00D;
    tick();
    tests++;
    if ({bus.ram0_ren, bus.ram0_raddr, busy, bus.m0_ack} !== {1'b1, 32'h10, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL read_issue: ren=%b raddr=%h busy=%b ack=%b, want 1 00000010 1 0",
               bus.ram0_ren, bus.ram0_raddr, busy, bus.m0_ack);
    end
    tick();
    tests++;
    if ({bus.m0_ack, bus.m0_err, bus.m1_ack, bus.ram0_ren, bus.ram0_raddr} !== {4'b1000, 32'h0}) begin
      failed++;
      $display("FAIL read_ack: m0_ack=%b err=%b m1_ack=%b ren=%b raddr=%h, want 1 0 0 0 0",
               bus.m0_ack, bus.m0_err, bus.m1_ack, bus.ram0_ren, bus.ram0_raddr);
    end
    tests++;
    if (bus.m0_rdata !== 32'hCAFE_F00D) begin
      failed++;
      $display("FAIL read_data: got %h, want cafef00d", bus.m0_rdata);
    end
    bus.m0_req = 0; bus.ram0_rvalid = 0;
    tick();
    tests++;
    if ({bus.m0_ack, busy, owner} !== 3'b000) begin
      failed++;
      $display("FAIL read_idle: ack=%b busy=%b owner=%b, want 0 0 0", bus.m0_ack, busy, owner);
    end
  endtask

  task automatic test_write_m1();
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h20;
    bus.m1_wdata = 32'h1234_5678; bus.m1_sel = 4'b0011;
    tick();
    bus.ram0_rvalid = 1;  // must not complete a write
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({bus.ram0_wen, bus.ram0_waddr, bus.ram0_wdata, bus.ram0_sel, owner, bus.m1_ack}
          !== {1'b1, 32'h20, 32'h1234_5678, 4'b0011, 1'b1, 1'b0}) begin
        failed++;
        $display("FAIL write_hold[%0d]: wen=%b waddr=%h wdata=%h sel=%b owner=%b ack=%b, want 1 20 12345678 0011 1 0",
                 i, bus.ram0_wen, bus.ram0_waddr, bus.ram0_wdata, bus.ram0_sel, owner, bus.m1_ack);
      end
      if (i == 3) bus.ram0_wready = 1;
      tick();
    end
    tests++;
    if ({bus.m1_ack, bus.m1_err, bus.m0_ack, bus.ram0_wen, bus.ram0_waddr, bus.ram0_wdata, bus.ram0_sel}
        !== {4'b1000, 68'h0}) begin
      failed++;
      $display("FAIL write_ack: m1_ack=%b err=%b m0_ack=%b wen=%b waddr=%h wdata=%h sel=%b, want 1 0 0 0 0 0 0",
               bus.m1_ack, bus.m1_err, bus.m0_ack, bus.ram0_wen, bus.ram0_waddr, bus.ram0_wdata, bus.ram0_sel);
    end
    tests++;
    if (bus.m0_rdata !== 32'hCAFE_F00D) begin
      failed++;
      $display("FAIL rdata_held: got %h, want cafef00d", bus.m0_rdata);
    end
    bus.m1_req = 0; bus.m1_we = 0; bus.ram0_wready = 0; bus.ram0_rvalid = 0;
    tick();
  endtask

  task automatic test_round_robin();
    logic exp;
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h100;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h200;
    bus.ram0_rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 1);
      bus.ram0_rdata = 32'hA000_0000 + i;
      tick();
      tests++;
      if ({owner, bus.ram0_raddr} !== {exp, (exp ? 32'h200 : 32'h100)}) begin
        failed++;
        $display("FAIL rr_grant[%0d]: owner=%b raddr=%h, want %b %h",
                 i, owner, bus.ram0_raddr, exp, (exp ? 32'h200 : 32'h100));
      end
      tick();
      tests++;
      if ({bus.m0_ack, bus.m1_ack, (exp ? bus.m1_rdata : bus.m0_rdata)}
          !== {~exp, exp, 32'hA000_0000 + i}) begin
        failed++;
        $display("FAIL rr_ack[%0d]: m0_ack=%b m1_ack=%b rdata=%h, want %b %b %h",
                 i, bus.m0_ack, bus.m1_ack, (exp ? bus.m1_rdata : bus.m0_rdata),
                 ~exp, exp, 32'hA000_0000 + i);
      end
      if (i == 3) begin
        bus.m0_req = 0; bus.m1_req = 0; bus.ram0_rvalid = 0;
      end
      tick();
    end
  endtask

  task automatic test_fixed_prio();
    bus_fp.m0_req = 1; bus_fp.m0_addr = 32'h300;
    bus_fp.m1_req = 1; bus_fp.m1_addr = 32'h400;
    bus_fp.ram0_rvalid = 1; bus_fp.ram0_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({owner_fp, bus_fp.ram0_raddr} !== {1'b0, 32'h300}) begin
        failed++;
        $display("FAIL fp_grant[%0d]: owner=%b raddr=%h, want 0 00000300", i, owner_fp, bus_fp.ram0_raddr);
      end
      tick();
      tests++;
      if ({bus_fp.m0_ack, bus_fp.m1_ack} !== 2'b10) begin
        failed++;
        $display("FAIL fp_ack[%0d]: m0_ack=%b m1_ack=%b, want 1 0", i, bus_fp.m0_ack, bus_fp.m1_ack);
      end
      tick();
    end
    bus_fp.m0_req = 0; bus_fp.m1_req = 0; bus_fp.ram0_rvalid = 0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h40; bus.ram0_rvalid = 0;
    tick();
    tick();
    tests++;
    if (bus.ram0_ren !== 1'b1) begin
      failed++;
      $display("FAIL midrst_stall: ren=%b, want 1", bus.ram0_ren);
    end
    rst = 0;
    tick();
    tests++;
    if ({bus.ram0_ren, busy, bus.m0_ack, owner} !== 4'b0001) begin
      failed++;
      $display("FAIL midrst_abort: ren=%b busy=%b ack=%b owner=%b, want 0 0 0 1",
               bus.ram0_ren, busy, bus.m0_ack, owner);
    end
    rst = 1;
    tick();
    tests++;
    if ({bus.ram0_ren, bus.ram0_raddr, owner} !== {1'b1, 32'h40, 1'b0}) begin
      failed++;
      $display("FAIL midrst_reissue: ren=%b raddr=%h owner=%b, want 1 00000040 0",
               bus.ram0_ren, bus.ram0_raddr, owner);
    end
    bus.ram0_rvalid = 1; bus.ram0_rdata = 32'h5555_AAAA;
    tick();
    tests++;
    if ({bus.m0_ack, bus.m0_rdata} !== {1'b1, 32'h5555_AAAA}) begin
      failed++;
      $display("FAIL midrst_done: ack=%b rdata=%h, want 1 5555aaaa", bus.m0_ack, bus.m0_rdata);
    end
    bus.m0_req = 0; bus.ram0_rvalid = 0;
    tick();
  endtask

  task automatic test_timeout();
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h80;
    bus.ram0_rvalid = 0; bus.ram0_rdata = 32'hDEAD_BEEF;
    tick();
`ifdef RAM0_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      tests++;
      if ({bus.ram0_ren, bus.m0_ack} !== 2'b10) begin
        failed++;
        $display("FAIL to_stall[%0d]: ren=%b ack=%b, want 1 0", i, bus.ram0_ren, bus.m0_ack);
      end
    end
    tick();
    tests++;
    if ({bus.ram0_ren, bus.m0_ack, bus.m0_err, bus.m0_rdata} !== {3'b011, 32'h0}) begin
      failed++;
      $display("FAIL to_abort: ren=%b ack=%b err=%b rdata=%h, want 0 1 1 0",
               bus.ram0_ren, bus.m0_ack, bus.m0_err, bus.m0_rdata);
    end
    tick();
    tick();
    for (int i = 0; i < 7; i++) tick();
    bus.ram0_rvalid = 1;
    tick();
    tests++;
    if ({bus.m0_ack, bus.m0_err, bus.m0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      failed++;
      $display("FAIL to_limit_handshake: ack=%b err=%b rdata=%h, want 1 0 deadbeef",
               bus.m0_ack, bus.m0_err, bus.m0_rdata);
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if ({bus.ram0_ren, bus.m0_ack, bus.m0_err} !== 3'b100) begin
        failed++;
        $display("FAIL nto_stall[%0d]: ren=%b ack=%b err=%b, want 1 0 0",
                 i, bus.ram0_ren, bus.m0_ack, bus.m0_err);
      end
    end
    bus.ram0_rvalid = 1;
    tick();
    tests++;
    if ({bus.m0_ack, bus.m0_err, bus.m0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      failed++;
      $display("FAIL nto_done: ack=%b err=%b rdata=%h, want 1 0 deadbeef",
               bus.m0_ack, bus.m0_err, bus.m0_rdata);
    end
`endif
    bus.m0_req = 0; bus.ram0_rvalid = 0;
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read_m0();
    test_write_m1();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid_read();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ram0_port_arbiter.md
# ram0_port_arbiter

Shares the single mapped RAM0 port between two requesters: m0, the tinycpu data port, and m1, the bench/loader port. Each transaction is a single 32-bit read or a byte-selectable write. The block arbitrates between pending requests and drives the RAM0 read/write handshakes (ren/rvalid, wen/wready). It returns a one-cycle acknowledge with read data to the winner. The block sits between tinycpu and the RAM0 pins of lab_top, clocked by step_clk.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: cycles a RAM handshake may stall before abort (only with the timeout feature).
- FIXED_PRIO, 0: 0 = round-robin; 1 = m0 always wins ties.

Ports:
- clk  in  1  system clock (step_clk); all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- mX_req  in  1  request, X in {0,1}; held with payload until mX_ack.
- mX_we  in  1  1 = write, 0 = read.
- mX_addr  in  32  byte address.
- mX_wdata  in  32  write data.
- mX_sel  in  4  byte enables for writes.
- mX_ack  out  1  one-cycle completion pulse.
- mX_rdata  out  32  read data, valid while mX_ack = 1, held until next read ack.
- mX_err  out  1  timeout abort flag, valid with mX_ack.
- ram0_raddr  out  32  read address.
- ram0_ren  out  1  read request.
- ram0_rdata  in  32  read data.
- ram0_rvalid  in  1  read data valid.
- ram0_waddr  out  32  write address.
- ram0_wdata  out  32  write data.
- ram0_wen  out  1  write request.
- ram0_sel  out  4  write byte enables.
- ram0_wready  in  1  write accepted.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  requester currently or last granted (0 = m0, 1 = m1).

## Operation
- FSM has four states: IDLE, RD, WR, DONE. Reset state is IDLE.
- IDLE behaviour:
  - If any mX_req is high, pick the winner.
  - Latch the winner's we/addr/wdata/sel into internal registers and set owner.
  - Go to RD (we = 0) or WR (we = 1).
- Winner selection:
  - With one request, that requester wins.
  - With both, the winner is m0 if FIXED_PRIO = 1; otherwise it is the requester that is not owner.
  - owner resets to 1, so m0 wins the first tie.
- RD state:
  - ram0_ren = 1 and ram0_raddr = latched address.
  - When ram0_rvalid is sampled high, capture ram0_rdata into mX_rdata of the owner and go to DONE.
- WR state:
  - ram0_wen = 1; ram0_waddr, ram0_wdata and ram0_sel are driven from the latches.
  - When ram0_wready is sampled high, go to DONE.
- DONE state:
  - The owner's mX_ack = 1 for exactly this cycle; all requests are ignored.
  - Next state is IDLE.
- Request hold: a requester still holding req in the IDLE cycle after its ack is issuing a new transaction.
- Address/data outputs are 0 whenever the matching ren/wen is low.
- Non-owner ack/err are always 0.
- Reset asserted mid-transaction:
  - Next edge returns to IDLE and drops ren/wen.
  - The pending transaction is discarded with no ack.

## Timing
- Reset values: every output is 0 except owner = 1. This covers all acks, errs, rdata, ren, wen, addresses, wdata, sel and busy.
- Request sampled in IDLE at cycle N:
  - ren/wen assert at N+1.
  - A handshake sampled at cycle M ≥ N+1 gives ack at M+1.
  - FSM is back in IDLE at M+2.
- Minimum request-to-ack latency is 2 cycles. Peak throughput is one transaction per 3 cycles.
- ren/wen stay high continuously until the handshake cycle. They are low in DONE and IDLE.
- A request arriving during RD/WR/DONE waits and is arbitrated in the next IDLE.
- rvalid or wready arriving outside RD/WR respectively is ignored.

## Configuration
- Macro RAM0_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RD/WR and increments each cycle without a handshake.
  - When the counter reaches TIMEOUT_CYCLES, drop ren/wen and go to DONE with mX_ack = 1 and mX_err = 1.
  - On a read abort, mX_rdata = 32'h0000_0000.
  - A handshake in the same cycle as the limit wins (normal completion, err = 0).
- Undefined:
  - No counter; RD/WR wait indefinitely.
  - mX_err is tied 0.

## Test plan
- m0 read addr 0x10, RAM returns rvalid with 0xCAFE_F00D in the first RD cycle -> ren high for 1 cycle, m0_ack at cycle 2, m0_rdata = 0xCAFE_F00D, m1_ack stays 0.
- m1 write addr 0x20, data 0x1234_5678, sel 4'b0011, wready delayed 3 cycles -> wen high for 4 cycles with stable waddr/wdata/sel, m1_ack one cycle after wready, owner = 1.
- Both req continuously, FIXED_PRIO = 0 -> grants alternate m0, m1, m0, m1; with FIXED_PRIO = 1 -> m0 only.
- Reset (rst = 0) during RD with ren high -> next cycle ren = 0, busy = 0, no ack; first transaction after reset completes normally.
- RAM0_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, rvalid never asserted -> ren drops after 8 RD cycles, m0_ack = 1, m0_err = 1, m0_rdata = 0; without macro, ren stays high indefinitely.
